dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_starve.sv | 38 +++
 rtl/dmem_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU
// memory stage and the loader/debug port.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_LD  = 2'd2
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 8;
  localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Saturating starvation counter: clear wins over enable, holds at LIMIT.
module starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic at_limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, the loader is granted
// when the CPU is idle or once it has waited STARVE_LIMIT cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [WIDTH-1:0] ld_adr,
  input  logic [WIDTH-1:0] ld_wdata,
  output logic [WIDTH-1:0] ld_rdata,
  output logic             ld_ack,
  output logic [WIDTH-1:0] ram_adr,
  output logic [WIDTH-1:0] ram_write_data,
  output logic             ram_write_enable,
  input  logic [WIDTH-1:0] ram_read_data
);

  arb_state_e       state_q, state_d;
  logic             cpu_grant, ld_grant;
  logic             starve_at_limit;
  logic             ld_ack_q;
  logic [WIDTH-1:0] ld_rdata_q, ld_rdata_d;

  // The ack cycle (GNT_LD) is never eligible, so a held ld_req only counts
  // as a fresh request from the cycle after the ack.
  always_comb begin
    ld_grant  = 1'b0;
    cpu_grant = 1'b0;
    if (rst_n) begin
      if (ld_req && (state_q != GNT_LD) && (!cpu_req || starve_at_limit)) begin
        ld_grant = 1'b1;
      end else if (cpu_req) begin
        cpu_grant = 1'b1;
      end
    end

    state_d = IDLE;
    if (ld_grant) begin
      state_d = GNT_LD;
    end else if (cpu_grant) begin
      state_d = GNT_CPU;
    end

    ram_adr          = '0;
    ram_write_data   = '0;
    ram_write_enable = 1'b0;
    if (cpu_grant) begin
      ram_adr          = cpu_adr;
      ram_write_data   = cpu_wdata;
      ram_write_enable = cpu_we;
    end else if (ld_grant) begin
      ram_adr          = ld_adr;
      ram_write_data   = ld_wdata;
      ram_write_enable = ld_we;
    end

    ld_rdata_d = ld_grant ? ram_read_data : ld_rdata_q;
  end

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!ld_req || ld_grant),
    .en_i      (ld_req && !ld_grant && (state_q != GNT_LD)),
    .at_limit_o(starve_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_ack_q   <= 1'b0;
      ld_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_ack_q   <= ld_grant;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  assign cpu_rdata = cpu_grant ? ram_read_data : '0;
  assign cpu_stall = cpu_req && !cpu_grant;
  assign ld_rdata  = ld_rdata_q;
  assign ld_ack    = ld_ack_q;

endmodule
